// File: rtl/serial_word_comparator_if.sv
// Digit-serial comparator bus.
//   master: drives clear, in_valid and the a/b digits; observes the result.
//   slave : the comparator; consumes digits, drives out_valid, the held
//           less/equal/greater result and the early-decision flag.
interface serial_word_comparator_if #(
  parameter int unsigned DIGIT_W = 1
);
  logic               clear;
  logic               in_valid;
  logic [DIGIT_W-1:0] a;
  logic [DIGIT_W-1:0] b;
  logic               out_valid;
  logic               a_less_b;
  logic               a_eq_b;
  logic               a_greater_b;
  logic               decided;

  modport master (
    output clear, in_valid, a, b,
    input  out_valid, a_less_b, a_eq_b, a_greater_b, decided
  );

  modport slave (
    input  clear, in_valid, a, b,
    output out_valid, a_less_b, a_eq_b, a_greater_b, decided
  );
endinterface

// File: rtl/serial_word_comparator.sv
// Framed digit-serial magnitude comparator.
// Two WIDTH-bit operands arrive DIGIT_W bits per beat (MSB- or LSB-first);
// a beat counter frames words of BEATS = WIDTH/DIGIT_W beats. Each completed
// word updates a held one-hot less/equal/greater result and pulses out_valid.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - slave side of serial_word_comparator_if (clear, in_valid, a, b in;
//          out_valid, a_less_b, a_eq_b, a_greater_b, decided out)
// WIDTH must be a multiple of DIGIT_W, and bus DIGIT_W must match DIGIT_W.
module serial_word_comparator #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DIGIT_W   = 1,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          SIGNED    = 1'b0
) (
  input logic                     clk,
  input logic                     rst,
  serial_word_comparator_if.slave bus
);

  localparam int unsigned BEATS     = WIDTH / DIGIT_W;
  localparam int unsigned CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned SIGN_BEAT = MSB_FIRST ? 0 : BEATS - 1;

  logic [CNT_W-1:0]   cnt_q;
  logic               run_lt_q, run_eq_q, run_gt_q;
  logic               out_valid_q, lt_q, eq_q, gt_q, decided_q;

  logic [DIGIT_W-1:0] a_m, b_m;
  logic               last_beat, sign_beat;
  logic               d_lt, d_gt;
  logic               nxt_lt, nxt_eq, nxt_gt;

  always_comb begin
    last_beat = (cnt_q == CNT_W'(BEATS - 1));
    sign_beat = (cnt_q == CNT_W'(SIGN_BEAT));

    // Flipping the sign bit maps two's complement onto offset binary, so an
    // unsigned digit compare then orders signed values correctly.
    a_m = bus.a;
    b_m = bus.b;
    if (SIGNED && sign_beat) begin
      a_m[DIGIT_W-1] = ~a_m[DIGIT_W-1];
      b_m[DIGIT_W-1] = ~b_m[DIGIT_W-1];
    end
    d_lt = (a_m < b_m);
    d_gt = (a_m > b_m);

    nxt_lt = run_lt_q;
    nxt_eq = run_eq_q;
    nxt_gt = run_gt_q;
    if (MSB_FIRST) begin
      // First differing digit from the top decides; later digits are ignored.
      if (run_eq_q) begin
        nxt_lt = d_lt;
        nxt_eq = ~(d_lt | d_gt);
        nxt_gt = d_gt;
      end
    end else if (d_lt | d_gt) begin
      // Later digits are more significant, so any difference overrides.
      nxt_lt = d_lt;
      nxt_eq = 1'b0;
      nxt_gt = d_gt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      run_lt_q    <= 1'b0;
      run_eq_q    <= 1'b1;
      run_gt_q    <= 1'b0;
      out_valid_q <= 1'b0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b1;
      gt_q        <= 1'b0;
      decided_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (bus.clear) begin
        // Abort the partial word; the held result is left alone.
        cnt_q     <= '0;
        run_lt_q  <= 1'b0;
        run_eq_q  <= 1'b1;
        run_gt_q  <= 1'b0;
        decided_q <= 1'b0;
      end else if (bus.in_valid) begin
        if (last_beat) begin
          lt_q        <= nxt_lt;
          eq_q        <= nxt_eq;
          gt_q        <= nxt_gt;
          out_valid_q <= 1'b1;
          cnt_q       <= '0;
          run_lt_q    <= 1'b0;
          run_eq_q    <= 1'b1;
          run_gt_q    <= 1'b0;
          decided_q   <= 1'b0;
        end else begin
          cnt_q     <= cnt_q + CNT_W'(1);
          run_lt_q  <= nxt_lt;
          run_eq_q  <= nxt_eq;
          run_gt_q  <= nxt_gt;
          decided_q <= MSB_FIRST & ~nxt_eq;
        end
      end
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.a_less_b    = lt_q;
  assign bus.a_eq_b      = eq_q;
  assign bus.a_greater_b = gt_q;
  assign bus.decided     = decided_q;

endmodule
